// File: rtl/comparator_scan_controller.sv
// comparator_scan_controller
// Steps the comparator pulse injector through a DAC scan. Each step loads a
// DAC code, clears the injector error counters, settles, fires a programmed
// number of pulses via the fire_pulse / pulser_ready handshake, waits for the
// counters to settle and then offers the captured error counts as a result
// that software must acknowledge before the next step begins.

module comparator_scan_controller #(
  parameter int STEP_W  = 8,
  parameter int TRIAL_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [STEP_W-1:0]  num_steps,
  input  logic [TRIAL_W-1:0] num_trials,
  input  logic [STEP_W-1:0]  dac_start,
  input  logic [STEP_W-1:0]  dac_stride,
  input  logic [7:0]         settle_cycles,
  output logic [STEP_W-1:0]  dac_code,
  output logic               dac_load,
  output logic               fire_pulse,
  input  logic               pulser_ready,
  output logic               halfstrips_errcnt_rst,
  output logic               compout_errcnt_rst,
  input  logic [31:0]        halfstrips_errcnt,
  input  logic [31:0]        compout_errcnt,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic               result_valid,
  input  logic               result_ack,
  output logic [STEP_W-1:0]  result_step,
  output logic [31:0]        result_hs_errs,
  output logic [31:0]        result_co_errs,
  output logic [TRIAL_W-1:0] trial_count
);

  // Handshake timer must hold values up to TIMEOUT-1; DRAIN reuses it to
  // count its two cycles.
  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DRAIN_END = TMR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_FIRE,
    S_WAIT_BUSY,
    S_WAIT_READY,
    S_DRAIN,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Scan configuration captured when a start is accepted.
  logic [STEP_W-1:0]  steps_q;
  logic [TRIAL_W-1:0] trials_q;
  logic [STEP_W-1:0]  stride_q;
  logic [7:0]         settle_q;

  // Per-step working registers.
  logic [STEP_W-1:0]  step_q;
  logic [STEP_W-1:0]  dac_code_q;
  logic [TRIAL_W-1:0] trial_count_q;
  logic [7:0]         settle_left_q;
  logic [TMR_W-1:0]   timer_q;

  // Status and result registers.
  logic               timeout_err_q;
  logic               result_valid_q;
  logic [STEP_W-1:0]  result_step_q;
  logic [31:0]        result_hs_q;
  logic [31:0]        result_co_q;

  // Decoded events.
  logic abort_hit;
  logic start_hit;
  logic settle_done;
  logic wait_expired;
  logic last_step;
  logic more_trials;
  logic step_advance;
  logic next_load;
  logic drain_capture;
  logic tmo_hit;

  assign abort_hit     = abort && (state_q != S_IDLE);
  assign start_hit     = start && !abort && (state_q == S_IDLE);
  // A settle count of 0 or 1 both give a single SETTLE cycle.
  assign settle_done   = (settle_left_q <= 8'd1);
  assign wait_expired  = (timer_q == TMR_LAST);
  // Compared at STEP_W width so the final step of a 2^STEP_W-1 scan
  // terminates without the step counter wrapping first.
  assign last_step     = ((step_q + STEP_W'(1)) == steps_q);
  assign more_trials   = (trial_count_q < trials_q);
  assign step_advance  = (state_q == S_REPORT) && result_ack && !abort;
  assign next_load     = step_advance && !last_step;
  assign drain_capture = (state_q == S_DRAIN) && (timer_q == DRAIN_END) && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked register uses non-blocking assignment so all
    // flops update together from the values sampled at the same edge.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; abort overrides everything else in a non-IDLE state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_hit) state_d = (num_steps == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: state_d = S_SETTLE;
      S_SETTLE: begin
        if (settle_done) begin
          if (trials_q == '0)   state_d = S_DRAIN;
          else if (pulser_ready) state_d = S_FIRE;
        end
      end
      S_FIRE: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!pulser_ready) begin
          state_d = S_WAIT_READY;
        end else if (wait_expired) begin
          state_d = S_DONE;
          tmo_hit = 1'b1;
        end
      end
      S_WAIT_READY: begin
        if (pulser_ready) begin
          state_d = more_trials ? S_FIRE : S_DRAIN;
        end else if (wait_expired) begin
          state_d = S_DONE;
          tmo_hit = 1'b1;
        end
      end
      S_DRAIN: begin
        if (timer_q == DRAIN_END) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (result_ack) state_d = last_step ? S_DONE : S_LOAD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      tmo_hit = 1'b0;
    end
  end

  // Configuration capture on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q  <= '0;
      trials_q <= '0;
      stride_q <= '0;
      settle_q <= '0;
    end else if (start_hit) begin
      steps_q  <= num_steps;
      trials_q <= num_trials;
      stride_q <= dac_stride;
      settle_q <= settle_cycles;
    end
  end

  // Step index and DAC code; the code is set as LOAD is entered so it is
  // already valid while dac_load is high, and wraps modulo 2^STEP_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q     <= '0;
      dac_code_q <= '0;
    end else if (start_hit) begin
      step_q <= '0;
      if (num_steps != '0) dac_code_q <= dac_start;
    end else if (step_advance) begin
      step_q <= step_q + STEP_W'(1);
      if (!last_step) dac_code_q <= dac_code_q + stride_q;
    end
  end

  // Pulses fired in the current step; zero from LOAD onwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trial_count_q <= '0;
    end else if (start_hit || next_load) begin
      trial_count_q <= '0;
    end else if ((state_q == S_FIRE) && !abort) begin
      trial_count_q <= trial_count_q + TRIAL_W'(1);
    end
  end

  // Settle down-counter, armed during LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_left_q <= '0;
    end else if (state_q == S_LOAD) begin
      settle_left_q <= settle_q;
    end else if ((state_q == S_SETTLE) && !settle_done) begin
      settle_left_q <= settle_left_q - 8'd1;
    end
  end

  // Cycle timer for the two handshake waits and DRAIN; restarts on every
  // state change so each wait gets its own TIMEOUT budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if (state_q inside {S_WAIT_BUSY, S_WAIT_READY, S_DRAIN}) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Sticky handshake-timeout flag; only a new accepted start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         timeout_err_q <= 1'b0;
    else if (start_hit) timeout_err_q <= 1'b0;
    else if (tmo_hit)   timeout_err_q <= 1'b1;
  end

  // Result capture at the end of DRAIN, release on acknowledge or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured counts drive ports directly, so they are reset
    // like control state rather than left as unreset data.
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      result_step_q  <= '0;
      result_hs_q    <= '0;
      result_co_q    <= '0;
    end else if (abort_hit) begin
      result_valid_q <= 1'b0;
    end else if (drain_capture) begin
      result_valid_q <= 1'b1;
      result_step_q  <= step_q;
      result_hs_q    <= halfstrips_errcnt;
      result_co_q    <= compout_errcnt;
    end else if (step_advance) begin
      result_valid_q <= 1'b0;
    end
  end

  // Moore outputs: strobes last exactly one cycle because their states do.
  assign dac_code              = dac_code_q;
  assign dac_load              = (state_q == S_LOAD);
  assign halfstrips_errcnt_rst = (state_q == S_LOAD);
  assign compout_errcnt_rst    = (state_q == S_LOAD);
  assign fire_pulse            = (state_q == S_FIRE);
  assign busy                  = (state_q != S_IDLE);
  // A timeout also lands in DONE, but with the sticky flag set.
  assign done                  = (state_q == S_DONE) && !timeout_err_q;
  assign timeout_err           = timeout_err_q;
  assign result_valid          = result_valid_q;
  assign result_step           = result_step_q;
  assign result_hs_errs        = result_hs_q;
  assign result_co_errs        = result_co_q;
  assign trial_count           = trial_count_q;

endmodule

// File: tb/tb_comparator_scan_controller.sv
// Bench for comparator_scan_controller: an injector model answers fire
// requests, a scoreboard holds the DAC codes and step results the scan must
// produce, and a negedge monitor compares DUT activity against it.

module tb_comparator_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_steps = '0;
  logic [15:0] num_trials = '0;
  logic [7:0]  dac_start = '0;
  logic [7:0]  dac_stride = '0;
  logic [7:0]  settle_cycles = '0;
  logic [7:0]  dac_code;
  logic        dac_load;
  logic        fire_pulse;
  logic        pulser_ready = 1'b1;
  logic        halfstrips_errcnt_rst;
  logic        compout_errcnt_rst;
  logic [31:0] halfstrips_errcnt = '0;
  logic [31:0] compout_errcnt = '0;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        result_valid;
  logic        result_ack = 1'b0;
  logic [7:0]  result_step;
  logic [31:0] result_hs_errs;
  logic [31:0] result_co_errs;
  logic [15:0] trial_count;

  comparator_scan_controller #(.STEP_W(8), .TRIAL_W(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_steps(num_steps), .num_trials(num_trials), .dac_start(dac_start),
    .dac_stride(dac_stride), .settle_cycles(settle_cycles),
    .dac_code(dac_code), .dac_load(dac_load), .fire_pulse(fire_pulse),
    .pulser_ready(pulser_ready),
    .halfstrips_errcnt_rst(halfstrips_errcnt_rst),
    .compout_errcnt_rst(compout_errcnt_rst),
    .halfstrips_errcnt(halfstrips_errcnt), .compout_errcnt(compout_errcnt),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .result_valid(result_valid), .result_ack(result_ack),
    .result_step(result_step), .result_hs_errs(result_hs_errs),
    .result_co_errs(result_co_errs), .trial_count(trial_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard.
  typedef struct {
    int step;
    int hs;
    int co;
  } res_t;

  int   exp_dac_q[$];
  res_t exp_res_q[$];
  int   exp_trials = 0;
  int   obs_dac_q[$];
  int   obs_hs_q[$];

  // Injector model controls.
  int err_trial = 0;
  bit stuck = 1'b0;
  bit auto_ack = 1'b1;
  int stray_req = 0;

  // Injector: after a fire request it keeps ready high one more cycle, drops
  // it for three cycles, then raises it and bumps both error counters if
  // this was the designated faulty trial of the step.
  int inj_cnt = 0;
  int inj_trial = 0;
  always begin
    @(posedge clk);
    #2;
    if (halfstrips_errcnt_rst) halfstrips_errcnt = '0;
    if (compout_errcnt_rst) compout_errcnt = '0;
    if (halfstrips_errcnt_rst || compout_errcnt_rst) inj_trial = 0;
    if (inj_cnt > 0) begin
      inj_cnt--;
      pulser_ready = !(inj_cnt inside {[1:3]});
      if (inj_cnt == 0 && inj_trial == err_trial) begin
        halfstrips_errcnt = halfstrips_errcnt + 32'd1;
        compout_errcnt    = compout_errcnt + 32'd1;
      end
    end else if (fire_pulse && !stuck) begin
      inj_cnt = 5;
      inj_trial++;
    end
  end

  // Software side: acknowledges a pending result after a short delay, and
  // issues requested stray acknowledges while nothing is pending.
  int ack_wait = 0;
  int stray_done = 0;
  always begin
    @(posedge clk);
    #2;
    result_ack = 1'b0;
    if (stray_req != stray_done && !result_valid) begin
      result_ack = 1'b1;
      stray_done++;
    end else if (auto_ack && result_valid) begin
      if (ack_wait == 2) begin
        result_ack = 1'b1;
        ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end else begin
      ack_wait = 0;
    end
  end

  // Compare process.
  bit mon_en = 1'b0;
  bit have_dac = 1'b0;
  int cur_dac = 0;
  bit fire_armed = 1'b1;
  bit seen_low = 1'b0;
  int fires_step = 0;
  int fires_total = 0;
  int done_cnt = 0;
  bit rv_prev = 1'b0;

  always @(negedge clk) begin : monitor
    res_t e;
    if (mon_en) begin
      if (!busy) begin
        fire_armed = 1'b1;
        seen_low = 1'b0;
      end
      if (dac_load || halfstrips_errcnt_rst || compout_errcnt_rst) begin
        check("load_strobes", {dac_load, halfstrips_errcnt_rst, compout_errcnt_rst}, 3'b111);
        check("load_expected", exp_dac_q.size() > 0, 1);
        if (exp_dac_q.size() > 0) begin
          cur_dac = exp_dac_q.pop_front();
          have_dac = 1'b1;
        end
        obs_dac_q.push_back(int'(dac_code));
        check("load_trial_count", trial_count, 0);
        fires_step = 0;
      end
      if (have_dac) check("dac_code", dac_code, cur_dac);
      if (fire_pulse) begin
        check("fire_after_ready_cycle", fire_armed, 1);
        check("fire_busy", busy, 1);
        fire_armed = 1'b0;
        seen_low = 1'b0;
        fires_step++;
        fires_total++;
      end else if (!pulser_ready) begin
        seen_low = 1'b1;
      end else if (seen_low) begin
        fire_armed = 1'b1;
      end
      if (result_valid && !rv_prev) begin
        check("result_expected", exp_res_q.size() > 0, 1);
        if (exp_res_q.size() > 0) begin
          e = exp_res_q.pop_front();
          check("result_step", result_step, e.step);
          check("result_hs_errs", result_hs_errs, e.hs);
          check("result_co_errs", result_co_errs, e.co);
        end
        check("result_trial_count", trial_count, exp_trials);
        check("result_fires", fires_step, exp_trials);
        obs_hs_q.push_back(int'(result_hs_errs));
      end
      rv_prev = result_valid;
      if (done) done_cnt++;
    end
  end

  int done_base = 0;
  int fires_base = 0;

  // Build the expected scan from the configuration, then start it. Only the
  // first n_loads loads and n_results results are expected (fewer when the
  // scan is cut short). Config inputs are scrambled afterwards because the
  // DUT must have latched them.
  task automatic scan_begin(input int steps, input int trials, input int dstart,
                            input int dstride, input int settle, input int etrial,
                            input int n_loads, input int n_results);
    int e;
    exp_dac_q.delete();
    exp_res_q.delete();
    obs_dac_q.delete();
    obs_hs_q.delete();
    for (int s = 0; s < n_loads; s++) exp_dac_q.push_back((dstart + s * dstride) % 256);
    e = (etrial >= 1 && etrial <= trials) ? 1 : 0;
    for (int s = 0; s < n_results; s++) exp_res_q.push_back('{s, e, e});
    exp_trials = trials;
    err_trial  = etrial;
    done_base  = done_cnt;
    fires_base = fires_total;
    @(posedge clk);
    #1;
    num_steps     = 8'(steps);
    num_trials    = 16'(trials);
    dac_start     = 8'(dstart);
    dac_stride    = 8'(dstride);
    settle_cycles = 8'(settle);
    start = 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    num_steps     = 8'h5A;
    num_trials    = 16'h0007;
    dac_start     = 8'hC3;
    dac_stride    = 8'h11;
    settle_cycles = 8'h09;
  endtask

  task automatic scan_end(input string tag, input int exp_done, input bit exp_tout);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished_in_budget"}, n < 20000, 1);
    check({tag, "_loads_left"}, exp_dac_q.size(), 0);
    check({tag, "_results_left"}, exp_res_q.size(), 0);
    check({tag, "_done_pulses"}, done_cnt - done_base, exp_done);
    check({tag, "_timeout_err"}, timeout_err, exp_tout);
    check({tag, "_result_valid_idle"}, result_valid, 0);
  endtask

  task automatic pin_dac(input int idx, input int val);
    if (idx < obs_dac_q.size()) check("pin_dac_code", obs_dac_q[idx], val);
    else check("pin_dac_missing", obs_dac_q.size(), idx + 1);
  endtask

  task automatic wait_for(input string what, input int kind, input int limit);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (kind)
        0: hit = fire_pulse;
        1: hit = !pulser_ready;
        2: hit = result_valid;
        3: hit = timeout_err;
        default: hit = (obs_dac_q.size() >= kind - 3);
      endcase
    end
    check({"wait_", what}, hit, 1);
  endtask

  initial begin : watchdog
    #600000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dac_code", dac_code, 0);
    check("rst_strobes", {dac_load, halfstrips_errcnt_rst, compout_errcnt_rst, fire_pulse}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_regs", {result_step, result_hs_errs, result_co_errs} == '0, 1);
    check("rst_trial_count", trial_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic scan: error on trial 2 of every step.
    scan_begin(3, 4, 10, 5, 2, 2, 3, 3);
    scan_end("basic", 1, 1'b0);
    pin_dac(0, 10);
    pin_dac(1, 15);
    pin_dac(2, 20);
    check("basic_fires", fires_total - fires_base, 12);
    if (obs_hs_q.size() == 3) check("basic_pin_hs_step1", obs_hs_q[1], 1);
    else check("basic_result_count", obs_hs_q.size(), 3);

    // DAC code wraps modulo 256, settle of zero.
    scan_begin(3, 2, 250, 4, 0, 0, 3, 3);
    scan_end("wrap", 1, 1'b0);
    pin_dac(0, 250);
    pin_dac(1, 254);
    pin_dac(2, 2);

    // Injector never drops ready: timeout 256 cycles after FIRE.
    stuck = 1'b1;
    scan_begin(2, 3, 40, 1, 1, 0, 1, 0);
    wait_for("timeout_fire", 0, 50);
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 256);
    check("timeout_no_done", done, 0);
    @(negedge clk);
    check("timeout_busy_falls", busy, 0);
    scan_end("timeout", 0, 1'b1);
    check("timeout_single_fire", fires_total - fires_base, 1);
    stuck = 1'b0;

    // Zero trials: no pulses, zero counts; start clears the sticky timeout.
    scan_begin(2, 0, 7, 1, 3, 0, 2, 2);
    @(negedge clk);
    check("start_clears_timeout", timeout_err, 0);
    scan_end("zero_trials", 1, 1'b0);
    check("zero_trials_fires", fires_total - fires_base, 0);

    // Zero steps: done one cycle after start.
    scan_begin(0, 5, 99, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("zero_steps_done", done, 1);
    check("zero_steps_busy", busy, 1);
    @(negedge clk);
    check("zero_steps_done_once", done, 0);
    check("zero_steps_idle", busy, 0);
    scan_end("zero_steps", 1, 1'b0);

    // Abort in WAIT_READY of step 1.
    scan_begin(3, 2, 60, 10, 1, 1, 2, 1);
    wait_for("abort_step1_load", 5, 400);
    wait_for("abort_step1_fire", 0, 50);
    wait_for("abort_ready_low", 1, 20);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_wr_busy", busy, 0);
    check("abort_wr_valid", result_valid, 0);
    check("abort_wr_done", done, 0);
    check("abort_wr_fire", fire_pulse, 0);
    scan_end("abort_wait_ready", 0, 1'b0);

    // Abort while a result is pending and unacknowledged.
    auto_ack = 1'b0;
    scan_begin(2, 1, 5, 1, 0, 0, 1, 1);
    wait_for("abort_report_result", 2, 100);
    repeat (3) @(negedge clk);
    check("report_holds_valid", result_valid, 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_rp_valid", result_valid, 0);
    check("abort_rp_busy", busy, 0);
    scan_end("abort_report", 0, 1'b0);
    auto_ack = 1'b1;

    // Start while busy and a stray acknowledge are both ignored.
    scan_begin(3, 2, 100, 1, 1, 1, 3, 3);
    wait_for("ignored_first_fire", 0, 50);
    @(posedge clk);
    #1;
    num_steps = 8'd1;
    dac_start = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stray_req++;
    scan_end("ignored_inputs", 1, 1'b0);
    pin_dac(2, 102);

    // Maximum step count: all 255 steps, no step wrap, DAC wraps.
    scan_begin(255, 1, 0, 3, 0, 1, 255, 255);
    scan_end("max_steps", 1, 1'b0);
    check("max_steps_loads", obs_dac_q.size(), 255);
    pin_dac(85, 255);
    pin_dac(86, 2);
    pin_dac(254, 250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
